// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode/hazard signal bundle between decode stage and hazard scoreboard
//
// Purpose: groups the decode-stage request signals and the hazard controller
// responses into one bundle.
// Ports (signals):
//   pipe_adv                      pipeline advances this cycle
//   id_valid, id_rs, id_rt        decode instruction valid and source selects
//   id_use_rs, id_use_rt          source actually read
//   id_wen, id_wsel, id_load      destination write enable/select, LW flag
//   id_branch, id_bne, id_equal   BEQ/BNE in decode, BNE select, operands equal
//   id_jump                       J/JAL/JR in decode
//   ctr_clear                     clear performance counters
//   stall, redirect, flush        hazard controls back to the pipeline
//   busy                          per-register pending-result flags
//   stall_cycles, redirect_count  performance counters
// Modports: master = decode side (drives requests), slave = scoreboard.
interface hazard_scoreboard_if #(
  parameter int NREGS  = 32,
  parameter int PERF_W = 32
) ();
  localparam int REG_W = $clog2(NREGS);

  logic              pipe_adv;
  logic              id_valid;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_wen;
  logic [REG_W-1:0]  id_wsel;
  logic              id_load;
  logic              id_branch;
  logic              id_bne;
  logic              id_equal;
  logic              id_jump;
  logic              ctr_clear;
  logic              stall;
  logic              redirect;
  logic              flush;
  logic [NREGS-1:0]  busy;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] redirect_count;

  modport master (
    output pipe_adv, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wen, id_wsel, id_load, id_branch, id_bne, id_equal,
           id_jump, ctr_clear,
    input  stall, redirect, flush, busy, stall_cycles, redirect_count
  );

  modport slave (
    input  pipe_adv, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wen, id_wsel, id_load, id_branch, id_bne, id_equal,
           id_jump, ctr_clear,
    output stall, redirect, flush, busy, stall_cycles, redirect_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register latency scoreboard with branch redirect and fetch flush
//
// Purpose: decode-stage hazard controller. Tracks, per architectural register,
// how many pipeline advances remain before its pending result is forwardable,
// stalls decode while a consumed source is busy, redirects fetch on taken
// branches/jumps and flushes IF/ID for FLUSH_CYC advancing cycles afterwards.
// Ports:
//   CLK   clock
//   nRST  synchronous active-low reset
//   sb    hazard_scoreboard_if.slave (decode requests in, hazard controls and
//         performance counters out)
module hazard_scoreboard #(
  parameter int NREGS     = 32,
  parameter int ALU_LAT   = 0,
  parameter int LD_LAT    = 1,
  parameter int FLUSH_CYC = 1,
  parameter int PERF_W    = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  hazard_scoreboard_if.slave sb
);
  localparam int REG_W   = $clog2(NREGS);
  localparam int MAX_LAT = (ALU_LAT > LD_LAT) ? ALU_LAT : LD_LAT;
  // Keep at least one bit of counter even when both latencies are zero.
  localparam int CNT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);
  localparam int FLUSH_W = $clog2(FLUSH_CYC + 1);

  localparam logic [CNT_W-1:0]   ALU_SET   = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0]   LD_SET    = CNT_W'(LD_LAT);
  localparam logic [FLUSH_W-1:0] FLUSH_SET = FLUSH_W'(FLUSH_CYC);

  logic [CNT_W-1:0]   cnt [NREGS];
  logic [FLUSH_W-1:0] flush_cnt;
  logic [PERF_W-1:0]  stall_cycles_q;
  logic [PERF_W-1:0]  redirect_count_q;

  logic [NREGS-1:0]   busy_vec;
  logic               flush_c;
  logic               stall_c;
  logic               issue;
  logic               taken;
  logic               redirect_c;
  logic               sb_write;
  logic [CNT_W-1:0]   set_val;

  // Register 0 is never written (sb_write excludes it), so its counter stays 0.
  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NREGS; r++) begin
      busy_vec[r] = (cnt[r] != '0);
    end
  end

  assign flush_c = (flush_cnt != '0);

  // Sources are checked against the pre-update scoreboard, so an instruction
  // whose destination equals its own source never stalls on itself.
  assign stall_c = sb.id_valid & ~flush_c &
                   ((sb.id_use_rs & busy_vec[sb.id_rs]) |
                    (sb.id_use_rt & busy_vec[sb.id_rt]));

  assign issue      = sb.id_valid & sb.pipe_adv & ~stall_c & ~flush_c;
  assign taken      = sb.id_jump | (sb.id_branch & (sb.id_equal ^ sb.id_bne));
  assign redirect_c = issue & taken;
  assign sb_write   = issue & sb.id_wen & (sb.id_wsel != '0);
  assign set_val    = sb.id_load ? LD_SET : ALU_SET;

  // Scoreboard: counts down only when the pipeline advances; a new write
  // overrides the decrement for its own entry.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt[r] <= '0;
      end
    end else if (sb.pipe_adv) begin
      for (int r = 0; r < NREGS; r++) begin
        if (sb_write && (sb.id_wsel == REG_W'(r))) begin
          cnt[r] <= set_val;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  // Flush window: opened by a redirect, shrinks only on advancing cycles.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      flush_cnt <= '0;
    end else if (redirect_c) begin
      flush_cnt <= FLUSH_SET;
    end else if (sb.pipe_adv && flush_cnt != '0) begin
      flush_cnt <= flush_cnt - 1'b1;
    end
  end

  // Saturating performance counters; clear wins over a same-cycle increment.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cycles_q   <= '0;
      redirect_count_q <= '0;
    end else if (sb.ctr_clear) begin
      stall_cycles_q   <= '0;
      redirect_count_q <= '0;
    end else begin
      if (stall_c && !(&stall_cycles_q)) begin
        stall_cycles_q <= stall_cycles_q + 1'b1;
      end
      if (redirect_c && !(&redirect_count_q)) begin
        redirect_count_q <= redirect_count_q + 1'b1;
      end
    end
  end

  assign sb.stall          = stall_c;
  assign sb.redirect       = redirect_c;
  assign sb.flush          = flush_c;
  assign sb.busy           = busy_vec;
  assign sb.stall_cycles   = stall_cycles_q;
  assign sb.redirect_count = redirect_count_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
//
// Purpose: drives directed decode sequences into hazard_scoreboard
// (NREGS=32, ALU_LAT=0, LD_LAT=1, FLUSH_CYC=2, PERF_W=4) and compares
// stall/redirect/flush/busy and counters against hand-computed values.
// Ports: none (top-level bench).
module tb_hazard_scoreboard;
  logic clk;
  logic nrst;
  int   n_checks;
  int   n_fails;

  hazard_scoreboard_if #(.NREGS(32), .PERF_W(4)) bus ();

  hazard_scoreboard #(
    .NREGS(32), .ALU_LAT(0), .LD_LAT(1), .FLUSH_CYC(2), .PERF_W(4)
  ) dut (
    .CLK  (clk),
    .nRST (nrst),
    .sb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic valid,
                         input logic [4:0] rs, input logic use_rs,
                         input logic [4:0] rt, input logic use_rt,
                         input logic wen, input logic [4:0] wsel,
                         input logic load);
    bus.id_valid  = valid;
    bus.id_rs     = rs;
    bus.id_use_rs = use_rs;
    bus.id_rt     = rt;
    bus.id_use_rt = use_rt;
    bus.id_wen    = wen;
    bus.id_wsel   = wsel;
    bus.id_load   = load;
    bus.id_branch = 1'b0;
    bus.id_bne    = 1'b0;
    bus.id_equal  = 1'b0;
    bus.id_jump   = 1'b0;
  endtask

  task automatic idle();
    set_ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    bus.pipe_adv  = 1'b1;
    bus.ctr_clear = 1'b0;
  endtask

  task automatic clear_ctrs();
    idle();
    bus.ctr_clear = 1'b1;
    tick();
    bus.ctr_clear = 1'b0;
  endtask

  task automatic test_reset();
    // LW r5 issues, leaving r5 busy.
    idle();
    set_ins(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1);
    tick();
    n_checks++;
    if (bus.busy[5] !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_pre_busy5: got %b expected 1", bus.busy[5]);
    end
    // Reset while a taken BEQ sits in decode.
    nrst = 1'b0;
    set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    bus.id_branch = 1'b1;
    bus.id_equal  = 1'b1;
    #1;
    n_checks++;
    if (bus.redirect !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_redirect_follows: got %b expected 1", bus.redirect);
    end
    tick();
    nrst = 1'b1;
    set_ins(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    #1;
    n_checks++;
    if (bus.busy !== 32'h0) begin
      n_fails++;
      $display("FAIL reset_busy: got %h expected 00000000", bus.busy);
    end
    n_checks++;
    if (bus.flush !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_flush: got %b expected 0", bus.flush);
    end
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_stall: got %b expected 0", bus.stall);
    end
    n_checks++;
    if (bus.stall_cycles !== 4'd0 || bus.redirect_count !== 4'd0) begin
      n_fails++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0",
               bus.stall_cycles, bus.redirect_count);
    end
    tick();
    idle();
  endtask

  task automatic test_load_use();
    clear_ctrs();
    // LW r5
    set_ins(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    #1;
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fails++;
      $display("FAIL lu_lw_stall: got %b expected 0", bus.stall);
    end
    tick();
    // ADD r6,r5,r1: one stall cycle
    set_ins(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b1, 5'd6, 1'b0);
    #1;
    n_checks++;
    if (bus.stall !== 1'b1) begin
      n_fails++;
      $display("FAIL lu_dep_stall: got %b expected 1", bus.stall);
    end
    tick();
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fails++;
      $display("FAIL lu_dep_release: got %b expected 0", bus.stall);
    end
    tick();
    // ADD r6,r6,r5 immediately after: ALU result forwardable, no stall
    set_ins(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0);
    #1;
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fails++;
      $display("FAIL lu_alu_b2b: got %b expected 0", bus.stall);
    end
    tick();
    idle();
    n_checks++;
    if (bus.stall_cycles !== 4'd1) begin
      n_fails++;
      $display("FAIL lu_stall_cycles: got %0d expected 1", bus.stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    clear_ctrs();
    set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    tick();
    // Dependent waits in decode while memory holds the pipeline.
    set_ins(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0);
    bus.pipe_adv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.busy[5] !== 1'b1 || bus.stall !== 1'b1) begin
        n_fails++;
        $display("FAIL mw_hold[%0d]: busy5=%b stall=%b expected 1/1",
                 i, bus.busy[5], bus.stall);
      end
      tick();
    end
    bus.pipe_adv = 1'b1;
    #1;
    n_checks++;
    if (bus.stall !== 1'b1) begin
      n_fails++;
      $display("FAIL mw_resume_stall: got %b expected 1", bus.stall);
    end
    tick();
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fails++;
      $display("FAIL mw_resume_release: got %b expected 0", bus.stall);
    end
    tick();
    idle();
    n_checks++;
    if (bus.stall_cycles !== 4'd4) begin
      n_fails++;
      $display("FAIL mw_stall_cycles: got %0d expected 4", bus.stall_cycles);
    end
  endtask

  task automatic test_branch_flush();
    clear_ctrs();
    // BNE with equal operands: not taken.
    set_ins(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0);
    bus.id_branch = 1'b1;
    bus.id_bne    = 1'b1;
    bus.id_equal  = 1'b1;
    #1;
    n_checks++;
    if (bus.redirect !== 1'b0) begin
      n_fails++;
      $display("FAIL br_bne_not_taken: got %b expected 0", bus.redirect);
    end
    tick();
    // BEQ taken.
    bus.id_bne = 1'b0;
    #1;
    n_checks++;
    if (bus.redirect !== 1'b1 || bus.flush !== 1'b0) begin
      n_fails++;
      $display("FAIL br_beq_taken: redirect=%b flush=%b expected 1/0",
               bus.redirect, bus.flush);
    end
    tick();
    // Wrong-path J that also looks like LW r9.
    set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1);
    bus.id_jump = 1'b1;
    #1;
    n_checks++;
    if (bus.flush !== 1'b1 || bus.redirect !== 1'b0 || bus.stall !== 1'b0) begin
      n_fails++;
      $display("FAIL br_flush1: flush=%b redirect=%b stall=%b expected 1/0/0",
               bus.flush, bus.redirect, bus.stall);
    end
    tick();
    n_checks++;
    if (bus.busy[9] !== 1'b0) begin
      n_fails++;
      $display("FAIL br_wrongpath_write: got %b expected 0", bus.busy[9]);
    end
    // Non-advancing cycle keeps the flush window open.
    bus.pipe_adv = 1'b0;
    #1;
    n_checks++;
    if (bus.flush !== 1'b1 || bus.redirect !== 1'b0) begin
      n_fails++;
      $display("FAIL br_flush_hold: flush=%b redirect=%b expected 1/0",
               bus.flush, bus.redirect);
    end
    tick();
    bus.pipe_adv = 1'b1;
    #1;
    n_checks++;
    if (bus.flush !== 1'b1 || bus.redirect !== 1'b0) begin
      n_fails++;
      $display("FAIL br_flush2: flush=%b redirect=%b expected 1/0",
               bus.flush, bus.redirect);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.flush !== 1'b0) begin
      n_fails++;
      $display("FAIL br_flush_end: got %b expected 0", bus.flush);
    end
    n_checks++;
    if (bus.redirect_count !== 4'd1) begin
      n_fails++;
      $display("FAIL br_redirect_count: got %0d expected 1", bus.redirect_count);
    end
    tick();
  endtask

  task automatic test_r0_self();
    // LW r0 never marks r0 busy.
    set_ins(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1);
    tick();
    set_ins(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd3, 1'b0);
    #1;
    n_checks++;
    if (bus.busy[0] !== 1'b0 || bus.stall !== 1'b0) begin
      n_fails++;
      $display("FAIL r0_use: busy0=%b stall=%b expected 0/0",
               bus.busy[0], bus.stall);
    end
    tick();
    // LW r7,0(r7): no stall on itself.
    set_ins(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1);
    #1;
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fails++;
      $display("FAIL self_dep_stall: got %b expected 0", bus.stall);
    end
    tick();
    set_ins(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd4, 1'b0);
    #1;
    n_checks++;
    if (bus.busy[7] !== 1'b1 || bus.stall !== 1'b1) begin
      n_fails++;
      $display("FAIL self_dep_next: busy7=%b stall=%b expected 1/1",
               bus.busy[7], bus.stall);
    end
    tick();
    tick();
    idle();
  endtask

  task automatic test_saturation();
    clear_ctrs();
    set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    tick();
    set_ins(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    bus.pipe_adv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    n_checks++;
    if (bus.stall_cycles !== 4'hF) begin
      n_fails++;
      $display("FAIL sat_stall_cycles: got %0d expected 15", bus.stall_cycles);
    end
    // Clear with a concurrent stall.
    bus.ctr_clear = 1'b1;
    #1;
    n_checks++;
    if (bus.stall !== 1'b1) begin
      n_fails++;
      $display("FAIL sat_clear_stall_present: got %b expected 1", bus.stall);
    end
    tick();
    bus.ctr_clear = 1'b0;
    n_checks++;
    if (bus.stall_cycles !== 4'd0) begin
      n_fails++;
      $display("FAIL sat_clear_wins: got %0d expected 0", bus.stall_cycles);
    end
    tick();
    n_checks++;
    if (bus.stall_cycles !== 4'd1) begin
      n_fails++;
      $display("FAIL sat_after_clear: got %0d expected 1", bus.stall_cycles);
    end
    idle();
    tick();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    nrst     = 1'b0;
    idle();
    tick();
    tick();
    nrst = 1'b1;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch_flush();
    test_r0_self();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end
endmodule
